victim_swap_ctrl: RTL and testbench

// - Dcache miss-handling controller, directly upstream of the 4-entry victim cache.
// - On a dcache miss it looks the line up in the victim cache and returns the hit line to the dcache;
//   on a victim miss it fetches the line from memory instead.
// - Writes the dcache's evicted line into the victim cache; dirty evicted lines are also written back to memory.
// - Owns the victim cache's shared tag input: drives the lookup tag, then the write tag.

---
 rtl/victim_pkg.sv | 30 +++
 rtl/victim_swap_ctrl_if.sv | 71 +++++++
 rtl/victim_swap_ctrl.sv | 175 +++++++++++++++++
 tb/tb_victim_swap_ctrl.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_pkg.sv
// Shared types and sizes for the dcache miss / victim-cache swap controller.
// Contents: line and tag widths, victim cache depth, perf counter width,
// controller state encoding and a saturating increment helper.
package victim_pkg;

    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int DCACHE_TAG_BITS   = 20;
    localparam int VICTIM_NO_OF_SETS = 4;
    localparam int PERF_CNT_W        = 32;

    typedef logic [DCACHE_LINE_WIDTH-1:0] line_t;
    typedef logic [DCACHE_TAG_BITS-1:0]   tag_t;
    typedef logic [PERF_CNT_W-1:0]        perf_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        EVICT,
        WB
    } vsc_state_e;

    // Counters stick at all-ones instead of wrapping.
    function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
        return (&v) ? v : v + perf_cnt_t'(1);
    endfunction

endpackage

// File: rtl/victim_swap_ctrl_if.sv
// Bundle of every handshake and data signal around the swap controller:
//   dcache miss request    : miss_valid, miss_ready, miss_tag
//   dcache eviction        : evict_valid, evict_dirty, evict_tag, evict_data
//   victim cache           : vc_tag, vc_data_in, vc_write, vc_hit, vc_data_out
//   memory fetch           : mem_req_valid, mem_req_ready, mem_req_tag,
//                            mem_rsp_valid, mem_rsp_data
//   dirty writeback        : wb_valid, wb_ready, wb_tag, wb_data
//   dcache fill            : fill_valid, fill_tag, fill_data, fill_from_vc
// modport master: the controller side. modport slave: the surrounding
// dcache, victim cache and memory.
interface victim_swap_ctrl_if;
    import victim_pkg::*;

    logic  miss_valid;
    logic  miss_ready;
    tag_t  miss_tag;

    logic  evict_valid;
    logic  evict_dirty;
    tag_t  evict_tag;
    line_t evict_data;

    tag_t  vc_tag;
    line_t vc_data_in;
    logic  vc_write;
    logic  vc_hit;
    line_t vc_data_out;

    logic  mem_req_valid;
    logic  mem_req_ready;
    tag_t  mem_req_tag;
    logic  mem_rsp_valid;
    line_t mem_rsp_data;

    logic  wb_valid;
    logic  wb_ready;
    tag_t  wb_tag;
    line_t wb_data;

    logic  fill_valid;
    tag_t  fill_tag;
    line_t fill_data;
    logic  fill_from_vc;

    modport master (
        input  miss_valid, miss_tag,
        output miss_ready,
        input  evict_valid, evict_dirty, evict_tag, evict_data,
        output vc_tag, vc_data_in, vc_write,
        input  vc_hit, vc_data_out,
        output mem_req_valid, mem_req_tag,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output wb_valid, wb_tag, wb_data,
        input  wb_ready,
        output fill_valid, fill_tag, fill_data, fill_from_vc
    );

    modport slave (
        output miss_valid, miss_tag,
        input  miss_ready,
        output evict_valid, evict_dirty, evict_tag, evict_data,
        input  vc_tag, vc_data_in, vc_write,
        output vc_hit, vc_data_out,
        input  mem_req_valid, mem_req_tag,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  wb_valid, wb_tag, wb_data,
        output wb_ready,
        input  fill_valid, fill_tag, fill_data, fill_from_vc
    );

endinterface

// File: rtl/victim_swap_ctrl.sv
// Dcache miss-handling controller in front of the 4-entry victim cache.
// A miss is looked up in the victim cache; a hit line is returned to the
// dcache, otherwise the line is fetched from memory. The line evicted by the
// dcache is then written into the victim cache, and written back to memory
// when dirty. The controller owns the victim cache's shared tag input.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   victim_swap_ctrl_if.master (miss/evict/vc/mem/wb/fill signals)
//   perf_vc_hits, perf_vc_misses   saturating lookup counters
//                                  (present only with VSC_PERF_CNT_EN)
//
// Optional feature macro: VSC_PERF_CNT_EN
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | miss_ready=1, waiting for a dcache miss
// LOOKUP   | vc_tag=miss tag, sample vc_hit / vc_data_out
// MEM_REQ  | mem_req_valid held until mem_req_ready
// MEM_WAIT | waiting for mem_rsp_valid
// FILL     | one-cycle fill pulse to the dcache
// EVICT    | one-cycle victim cache write of the evicted line (if valid)
// WB       | wb_valid held until wb_ready (dirty evicted line)
module victim_swap_ctrl
    import victim_pkg::*;
(
    input  logic clk,
    input  logic rst,
    victim_swap_ctrl_if.master bus
`ifdef VSC_PERF_CNT_EN
   ,output perf_cnt_t perf_vc_hits,
    output perf_cnt_t perf_vc_misses
`endif
);

    vsc_state_e state;
    tag_t       miss_tag_q;
    logic       ev_valid_q;
    logic       ev_dirty_q;
    tag_t       ev_tag_q;
    line_t      ev_data_q;

    // All outputs are registered: each is loaded on the transition into the
    // state that presents it. fill_data doubles as the line buffer and keeps
    // the last filled line; the other strobe/tag outputs return to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            miss_tag_q        <= '0;
            ev_valid_q        <= 1'b0;
            ev_dirty_q        <= 1'b0;
            ev_tag_q          <= '0;
            ev_data_q         <= '0;
            bus.miss_ready    <= 1'b1;
            bus.vc_tag        <= '0;
            bus.vc_data_in    <= '0;
            bus.vc_write      <= 1'b0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_tag   <= '0;
            bus.wb_valid      <= 1'b0;
            bus.wb_tag        <= '0;
            bus.wb_data       <= '0;
            bus.fill_valid    <= 1'b0;
            bus.fill_tag      <= '0;
            bus.fill_data     <= '0;
            bus.fill_from_vc  <= 1'b0;
`ifdef VSC_PERF_CNT_EN
            perf_vc_hits      <= '0;
            perf_vc_misses    <= '0;
`endif
        end else begin
            bus.vc_tag       <= '0;
            bus.vc_data_in   <= '0;
            bus.vc_write     <= 1'b0;
            bus.fill_valid   <= 1'b0;
            bus.fill_tag     <= '0;
            bus.fill_from_vc <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        miss_tag_q     <= bus.miss_tag;
                        ev_valid_q     <= bus.evict_valid;
                        ev_dirty_q     <= bus.evict_dirty;
                        ev_tag_q       <= bus.evict_tag;
                        ev_data_q      <= bus.evict_data;
                        bus.vc_tag     <= bus.miss_tag;
                        bus.miss_ready <= 1'b0;
                        state          <= LOOKUP;
                    end
                end

                LOOKUP: begin
                    // Tag 0 is never issued by the dcache, so a tag-0 hit
                    // against reset victim entries is taken at face value.
                    if (bus.vc_hit) begin
                        bus.fill_valid   <= 1'b1;
                        bus.fill_tag     <= miss_tag_q;
                        bus.fill_data    <= bus.vc_data_out;
                        bus.fill_from_vc <= 1'b1;
                        state            <= FILL;
                    end else begin
                        bus.mem_req_valid <= 1'b1;
                        bus.mem_req_tag   <= miss_tag_q;
                        state             <= MEM_REQ;
                    end
`ifdef VSC_PERF_CNT_EN
                    if (bus.vc_hit) begin
                        perf_vc_hits <= sat_inc(perf_vc_hits);
                    end else begin
                        perf_vc_misses <= sat_inc(perf_vc_misses);
                    end
`endif
                end

                MEM_REQ: begin
                    if (bus.mem_req_ready) begin
                        bus.mem_req_valid <= 1'b0;
                        bus.mem_req_tag   <= '0;
                        state             <= MEM_WAIT;
                    end
                end

                MEM_WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        bus.fill_valid <= 1'b1;
                        bus.fill_tag   <= miss_tag_q;
                        bus.fill_data  <= bus.mem_rsp_data;
                        state          <= FILL;
                    end
                end

                FILL: begin
                    // The hit line is left resident in the victim cache;
                    // FIFO replacement ages it out.
                    if (ev_valid_q) begin
                        bus.vc_write   <= 1'b1;
                        bus.vc_tag     <= ev_tag_q;
                        bus.vc_data_in <= ev_data_q;
                    end
                    state <= EVICT;
                end

                EVICT: begin
                    if (ev_valid_q && ev_dirty_q) begin
                        bus.wb_valid <= 1'b1;
                        bus.wb_tag   <= ev_tag_q;
                        bus.wb_data  <= ev_data_q;
                        state        <= WB;
                    end else begin
                        bus.miss_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end

                WB: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid   <= 1'b0;
                        bus.wb_tag     <= '0;
                        bus.wb_data    <= '0;
                        bus.miss_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: begin
                    bus.miss_ready <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Bench for victim_swap_ctrl: models the 4-entry FIFO victim cache, a memory
// responder and a writeback sink; fills and victim writes are checked against
// scoreboard queues filled when each miss is issued.
module tb_victim_swap_ctrl;
    import victim_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    victim_swap_ctrl_if bus();

`ifdef VSC_PERF_CNT_EN
    perf_cnt_t perf_vc_hits;
    perf_cnt_t perf_vc_misses;
`endif

    victim_swap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef VSC_PERF_CNT_EN
       ,.perf_vc_hits   (perf_vc_hits),
        .perf_vc_misses (perf_vc_misses)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Victim cache model: FIFO replacement, combinational lookup.
    tag_t  vc_tags  [VICTIM_NO_OF_SETS] = '{default: '0};
    line_t vc_lines [VICTIM_NO_OF_SETS] = '{default: '0};
    int    vc_ptr   = 0;
    logic  pl_valid = 1'b0;
    tag_t  pl_tag   = '0;
    line_t pl_data  = '0;

    always @(posedge clk) begin
        if (bus.vc_write) begin
            vc_tags[vc_ptr]  <= bus.vc_tag;
            vc_lines[vc_ptr] <= bus.vc_data_in;
            vc_ptr           <= (vc_ptr + 1) % VICTIM_NO_OF_SETS;
        end else if (pl_valid) begin
            vc_tags[vc_ptr]  <= pl_tag;
            vc_lines[vc_ptr] <= pl_data;
            vc_ptr           <= (vc_ptr + 1) % VICTIM_NO_OF_SETS;
        end
    end

    always_comb begin
        bus.vc_hit      = 1'b0;
        bus.vc_data_out = '0;
        for (int i = 0; i < VICTIM_NO_OF_SETS; i++) begin
            if (vc_tags[i] == bus.vc_tag) begin
                bus.vc_hit      = 1'b1;
                bus.vc_data_out = vc_lines[i];
            end
        end
    end

    typedef struct packed { tag_t tag; line_t data; logic from_vc; } fill_exp_t;
    typedef struct packed { tag_t tag; line_t data; } vcw_exp_t;
    fill_exp_t exp_fill[$];
    vcw_exp_t  exp_vcw[$];

    // Scoreboard monitor: every fill and victim write must match the head of
    // its queue; the idle controller must not drive the shared tag or strobes.
    always @(negedge clk) begin : monitor
        fill_exp_t ef;
        vcw_exp_t  ew;
        if (rst) begin
            if (bus.fill_valid) begin
                checks++;
                if (exp_fill.size() == 0) begin
                    failures++;
                    $display("FAIL fill_unexpected tag=%h", bus.fill_tag);
                end else begin
                    ef = exp_fill.pop_front();
                    if ({bus.fill_tag, bus.fill_data, bus.fill_from_vc} !== ef) begin
                        failures++;
                        $display("FAIL fill_content got tag=%h data=%h vc=%b want tag=%h data=%h vc=%b",
                                 bus.fill_tag, bus.fill_data, bus.fill_from_vc, ef.tag, ef.data, ef.from_vc);
                    end
                end
            end
            if (bus.vc_write) begin
                checks++;
                if (exp_vcw.size() == 0) begin
                    failures++;
                    $display("FAIL vc_write_unexpected tag=%h", bus.vc_tag);
                end else begin
                    ew = exp_vcw.pop_front();
                    if ({bus.vc_tag, bus.vc_data_in} !== ew) begin
                        failures++;
                        $display("FAIL vc_write_content got tag=%h data=%h want tag=%h data=%h",
                                 bus.vc_tag, bus.vc_data_in, ew.tag, ew.data);
                    end
                end
            end
            if (bus.miss_ready) begin
                checks++;
                if (bus.vc_tag !== '0 || bus.vc_write !== 1'b0 || bus.fill_valid !== 1'b0 ||
                    bus.mem_req_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_outputs got vc_tag=%h vc_write=%b fill=%b req=%b wb=%b want all 0",
                             bus.vc_tag, bus.vc_write, bus.fill_valid, bus.mem_req_valid, bus.wb_valid);
                end
            end
        end
    end

    // Responder configuration and per-transaction observations.
    int    mem_ready_delay = 1;
    bit    rsp_en          = 1'b1;
    line_t rsp_data        = '0;
    int    wb_ready_delay  = 0;

    int    obs_fill_c, obs_fill_n, obs_vcw_c, obs_vcw_n, obs_ready_c, obs_req_c;
    int    obs_wb_c, obs_wb_n, obs_wb_ready_c;
    tag_t  obs_req_tag, obs_lookup_tag, obs_wb_tag;
    line_t obs_wb_data;
    bit    obs_wb_stable, obs_timeout;

    function automatic bit outs_reset_state();
        return bus.miss_ready === 1'b1 && bus.vc_tag === '0 && bus.vc_data_in === '0 &&
               bus.vc_write === 1'b0 && bus.mem_req_valid === 1'b0 && bus.mem_req_tag === '0 &&
               bus.wb_valid === 1'b0 && bus.wb_tag === '0 && bus.wb_data === '0 &&
               bus.fill_valid === 1'b0 && bus.fill_tag === '0 && bus.fill_data === '0 &&
               bus.fill_from_vc === 1'b0;
    endfunction

    task automatic preload(input tag_t t, input line_t d);
        @(negedge clk);
        pl_valid = 1'b1;
        pl_tag   = t;
        pl_data  = d;
        @(negedge clk);
        pl_valid = 1'b0;
    endtask

    // Drives miss_valid for one cycle (cycle 0 = accept cycle).
    task automatic issue_miss(input tag_t t, input bit ev_v, input bit ev_d,
                              input tag_t ev_t, input line_t ev_dat);
        @(negedge clk);
        bus.miss_valid  = 1'b1;
        bus.miss_tag    = t;
        bus.evict_valid = ev_v;
        bus.evict_dirty = ev_d;
        bus.evict_tag   = ev_t;
        bus.evict_data  = ev_dat;
    endtask

    // Steps the transaction cycle by cycle, acting as memory and writeback
    // sink, and records when things happen. Ends when miss_ready returns.
    task automatic run_txn(input int max_cyc);
        int mem_cnt = 0;
        int wb_cnt  = 0;
        obs_fill_c = -1; obs_fill_n = 0; obs_vcw_c = -1; obs_vcw_n = 0;
        obs_ready_c = -1; obs_req_c = -1; obs_wb_c = -1; obs_wb_n = 0;
        obs_wb_ready_c = -1; obs_wb_stable = 1'b1; obs_timeout = 1'b1;
        obs_req_tag = '0; obs_lookup_tag = '0; obs_wb_tag = '0; obs_wb_data = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.miss_valid = 1'b0;
                obs_lookup_tag = bus.vc_tag;
            end
            bus.mem_rsp_valid = 1'b0;
            if (bus.fill_valid) begin
                obs_fill_n++;
                if (obs_fill_c < 0) obs_fill_c = c;
            end
            if (bus.vc_write) begin
                obs_vcw_n++;
                if (obs_vcw_c < 0) obs_vcw_c = c;
            end
            if (bus.mem_req_ready) begin
                bus.mem_req_ready = 1'b0;
                if (rsp_en) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = rsp_data;
                end
            end else if (bus.mem_req_valid) begin
                if (obs_req_c < 0) begin
                    obs_req_c   = c;
                    obs_req_tag = bus.mem_req_tag;
                end
                mem_cnt++;
                if (mem_cnt >= mem_ready_delay) bus.mem_req_ready = 1'b1;
            end
            if (bus.wb_ready) begin
                bus.wb_ready = 1'b0;
            end else if (bus.wb_valid) begin
                obs_wb_n++;
                if (obs_wb_c < 0) begin
                    obs_wb_c    = c;
                    obs_wb_tag  = bus.wb_tag;
                    obs_wb_data = bus.wb_data;
                end else if (bus.wb_tag !== obs_wb_tag || bus.wb_data !== obs_wb_data) begin
                    obs_wb_stable = 1'b0;
                end
                wb_cnt++;
                if (wb_cnt > wb_ready_delay) begin
                    bus.wb_ready   = 1'b1;
                    obs_wb_ready_c = c;
                end
            end
            if (bus.miss_ready) begin
                obs_ready_c = c;
                obs_timeout = 1'b0;
                break;
            end
        end
        checks++;
        if (obs_timeout) begin
            failures++;
            $display("FAIL txn_timeout miss_ready still %b after %0d cycles, want 1", bus.miss_ready, max_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (!outs_reset_state()) begin
            failures++;
            $display("FAIL reset_outputs got miss_ready=%b vc_tag=%h fill=%b req=%b wb=%b want ready=1 rest 0",
                     bus.miss_ready, bus.vc_tag, bus.fill_valid, bus.mem_req_valid, bus.wb_valid);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (!outs_reset_state()) begin
            failures++;
            $display("FAIL reset_release got miss_ready=%b want 1 with outputs 0", bus.miss_ready);
        end
    endtask

    line_t hit_ev_data = {4{32'h1230_0123}};

    task automatic test_victim_hit();
        line_t d = {4{32'hABCA_BC00}};
        preload(20'h00ABC, d);
        exp_fill.push_back('{tag: 20'h00ABC, data: d, from_vc: 1'b1});
        exp_vcw.push_back('{tag: 20'h00123, data: hit_ev_data});
        issue_miss(20'h00ABC, 1'b1, 1'b0, 20'h00123, hit_ev_data);
        run_txn(20);
        checks++;
        if (obs_lookup_tag !== 20'h00ABC) begin
            failures++;
            $display("FAIL hit_lookup_tag got %h want 00abc", obs_lookup_tag);
        end
        checks++;
        if (obs_fill_c !== 2 || obs_vcw_c !== 3 || obs_ready_c !== 4) begin
            failures++;
            $display("FAIL hit_latency got fill=%0d vcw=%0d ready=%0d want 2 3 4", obs_fill_c, obs_vcw_c, obs_ready_c);
        end
        checks++;
        if (obs_req_c !== -1) begin
            failures++;
            $display("FAIL hit_no_mem_req got mem_req at cycle %0d want none", obs_req_c);
        end
    endtask

    task automatic test_victim_miss();
        line_t ev = {4{32'h0012_4124}};
        mem_ready_delay = 3;
        rsp_data = {4{32'hDEAD_BEEF}};
        exp_fill.push_back('{tag: 20'h00777, data: rsp_data, from_vc: 1'b0});
        exp_vcw.push_back('{tag: 20'h00124, data: ev});
        issue_miss(20'h00777, 1'b1, 1'b0, 20'h00124, ev);
        run_txn(30);
        checks++;
        if (obs_req_c !== 2 || obs_req_tag !== 20'h00777) begin
            failures++;
            $display("FAIL miss_mem_req got cycle=%0d tag=%h want 2 00777", obs_req_c, obs_req_tag);
        end
        checks++;
        if (obs_fill_c !== 6 || obs_vcw_c !== 7 || obs_ready_c !== 8) begin
            failures++;
            $display("FAIL miss_latency got fill=%0d vcw=%0d ready=%0d want 6 7 8", obs_fill_c, obs_vcw_c, obs_ready_c);
        end
        mem_ready_delay = 1;
    endtask

    task automatic test_dirty_evict();
        line_t ev = {4{32'h5555_0555}};
        rsp_data = {4{32'h8888_0888}};
        wb_ready_delay = 4;
        exp_fill.push_back('{tag: 20'h00888, data: rsp_data, from_vc: 1'b0});
        exp_vcw.push_back('{tag: 20'h00555, data: ev});
        issue_miss(20'h00888, 1'b1, 1'b1, 20'h00555, ev);
        run_txn(40);
        checks++;
        if (obs_wb_c !== 6 || obs_wb_n !== 5 || obs_wb_stable !== 1'b1) begin
            failures++;
            $display("FAIL dirty_wb_hold got start=%0d cycles=%0d stable=%b want 6 5 1", obs_wb_c, obs_wb_n, obs_wb_stable);
        end
        checks++;
        if (obs_wb_tag !== 20'h00555 || obs_wb_data !== ev) begin
            failures++;
            $display("FAIL dirty_wb_content got tag=%h data=%h want 00555 %h", obs_wb_tag, obs_wb_data, ev);
        end
        checks++;
        if (obs_ready_c !== obs_wb_ready_c + 1 || obs_ready_c !== 11) begin
            failures++;
            $display("FAIL dirty_ready got ready=%0d wb_ready=%0d want 11 10", obs_ready_c, obs_wb_ready_c);
        end
        wb_ready_delay = 0;
    endtask

    task automatic test_evict_invalid();
        line_t d = {4{32'hA5A5_0A5A}};
        preload(20'h00A5A, d);
        exp_fill.push_back('{tag: 20'h00A5A, data: d, from_vc: 1'b1});
        issue_miss(20'h00A5A, 1'b0, 1'b1, 20'h00F0F, {4{32'hFFFF_0000}});
        run_txn(20);
        checks++;
        if (obs_vcw_n !== 0 || obs_wb_n !== 0 || obs_fill_c !== 2 || obs_ready_c !== 4) begin
            failures++;
            $display("FAIL evict_invalid got vcw=%0d wb=%0d fill=%0d ready=%0d want 0 0 2 4",
                     obs_vcw_n, obs_wb_n, obs_fill_c, obs_ready_c);
        end
    endtask

    // The line evicted in the hit test is still resident and swaps back in.
    task automatic test_swap_back();
        line_t ev = {4{32'h0321_0321}};
        exp_fill.push_back('{tag: 20'h00123, data: hit_ev_data, from_vc: 1'b1});
        exp_vcw.push_back('{tag: 20'h00321, data: ev});
        issue_miss(20'h00123, 1'b1, 1'b0, 20'h00321, ev);
        run_txn(20);
        checks++;
        if (obs_fill_n !== 1 || obs_req_c !== -1 || obs_ready_c !== 4) begin
            failures++;
            $display("FAIL swap_back got fills=%0d req=%0d ready=%0d want 1 -1 4", obs_fill_n, obs_req_c, obs_ready_c);
        end
    endtask

    task automatic test_reset_mid_op();
        issue_miss(20'h00999, 1'b0, 1'b0, 20'h0, '0);
        @(negedge clk);
        bus.miss_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req_valid !== 1'b1 || bus.mem_req_tag !== 20'h00999) begin
            failures++;
            $display("FAIL abort_mem_req got valid=%b tag=%h want 1 00999", bus.mem_req_valid, bus.mem_req_tag);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (!outs_reset_state()) begin
            failures++;
            $display("FAIL abort_outputs got miss_ready=%b req=%b fill=%b want ready=1 rest 0",
                     bus.miss_ready, bus.mem_req_valid, bus.fill_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = {4{32'h0BAD_0BAD}};
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (!outs_reset_state()) begin
                failures++;
                $display("FAIL abort_late_rsp got miss_ready=%b fill=%b fill_data=%h want ready=1 rest 0",
                         bus.miss_ready, bus.fill_valid, bus.fill_data);
            end
            @(negedge clk);
        end
    endtask

`ifdef VSC_PERF_CNT_EN
    task automatic test_perf_counters();
        line_t d;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (perf_vc_hits !== '0 || perf_vc_misses !== '0) begin
            failures++;
            $display("FAIL perf_reset got hits=%0d misses=%0d want 0 0", perf_vc_hits, perf_vc_misses);
        end
        for (int i = 1; i <= 3; i++) begin
            d = {4{32'hC000_0000 + 32'(i)}};
            preload(20'h00C00 + tag_t'(i), d);
            exp_fill.push_back('{tag: 20'h00C00 + tag_t'(i), data: d, from_vc: 1'b1});
            issue_miss(20'h00C00 + tag_t'(i), 1'b0, 1'b0, 20'h0, '0);
            run_txn(20);
        end
        for (int i = 1; i <= 2; i++) begin
            rsp_data = {4{32'hD000_0000 + 32'(i)}};
            exp_fill.push_back('{tag: 20'h00D00 + tag_t'(i), data: rsp_data, from_vc: 1'b0});
            issue_miss(20'h00D00 + tag_t'(i), 1'b0, 1'b0, 20'h0, '0);
            run_txn(30);
        end
        checks++;
        if (perf_vc_hits !== perf_cnt_t'(3) || perf_vc_misses !== perf_cnt_t'(2)) begin
            failures++;
            $display("FAIL perf_counts got hits=%0d misses=%0d want 3 2", perf_vc_hits, perf_vc_misses);
        end
    endtask
`endif

    initial begin
        bus.miss_valid    = 1'b0;
        bus.miss_tag      = '0;
        bus.evict_valid   = 1'b0;
        bus.evict_dirty   = 1'b0;
        bus.evict_tag     = '0;
        bus.evict_data    = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.wb_ready      = 1'b0;

        test_reset();
        test_victim_hit();
        test_victim_miss();
        test_dirty_evict();
        test_evict_invalid();
        test_swap_back();
        test_reset_mid_op();
`ifdef VSC_PERF_CNT_EN
        test_perf_counters();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (exp_fill.size() != 0 || exp_vcw.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got fills_left=%0d vcw_left=%0d want 0 0", exp_fill.size(), exp_vcw.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
